bus_mem_responder: RTL and testbench
====================================

# bus_mem_responder

Memory-side responder for the core's instruction and data buses: accepts `ibus_req_t` and `dbus_req_t` requests, arbitrates them onto one internal 64-bit word array, and answers each request after a fixed latency with a single-cycle `addr_ok`/`data_ok` response. It sits between the core and the simulation/SoC top level, standing in for the memory system behind `ireq`/`dreq`.

## Interface
- `MEM_WORDS`, 4096: depth of the word array, in 64-bit words; power of two.
- `LATENCY`, 2: cycles from request acceptance to the response cycle; ≥1.
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `ireq`  in  `ibus_req_t`  fields: `valid`, `addr[63:0]`.
- `iresp`  out  `ibus_resp_t`  fields: `addr_ok`, `data_ok`, `data[31:0]`.
- `dreq`  in  `dbus_req_t`  fields: `valid`, `addr[63:0]`, `size`, `strobe[7:0]`, `data[63:0]`.
- `dresp`  out  `dbus_resp_t`  fields: `addr_ok`, `data_ok`, `data[63:0]`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `err`  out  1  sticky out-of-range flag; cleared only by reset.

## Operation
- Protocol: the master holds `valid` and all request fields stable until it sees `data_ok`. The responder raises `addr_ok` and `data_ok` together for exactly one cycle, on the granted bus only.
- FSM states:
  - IDLE: accepts a request.
  - WAIT: counts down the latency.
  - RESP: drives the response.
- IDLE → WAIT (or → RESP directly when LATENCY=1) on any `valid`. On entry the FSM latches the grant, address, strobe, data and a kind flag (fetch, load or store), and loads the counter with LATENCY-2.
- WAIT → RESP when the counter reaches 0; otherwise the counter decrements.
- RESP → IDLE unconditionally.
- Arbitration, only in IDLE:
  - If only one bus is valid, grant it.
  - If both are valid, grant the bus not granted last (`last_grant` register).
  - `last_grant` resets to ibus, so dbus wins the first tie.
- Index = (addr − BASE_ADDR) >> 3, taken modulo MEM_WORDS only after the range check.
- In range: BASE_ADDR ≤ addr < BASE_ADDR + 8·MEM_WORDS.
- Read data is the array word at the index as it stands in the RESP cycle, i.e. before any write of the same transaction.
  - ibus: `data` = word[63:32] if addr[2], else word[31:0].
  - dbus: the full 64-bit word; `size` is informational only.
- Store: when `strobe` ≠ 0, byte *i* of the word is replaced by `dreq.data` byte *i* for every set `strobe[i]`. The write commits at the clock edge ending RESP.
- Out of range:
  - Read data is 0 and writes are dropped.
  - The response is still issued.
  - `err` sets at the end of RESP.
- A master dropping `valid` mid-transaction is a protocol violation. The transaction still completes, and the response pulse is still driven.

## Timing
- Request accepted in cycle T (IDLE with `valid`); response in cycle T+LATENCY; IDLE again in T+LATENCY+1, when a new request can be accepted.
- Sustained throughput: one transaction per LATENCY+1 cycles.
- `addr_ok`, `data_ok` and `data` are registered or decoded from state only, never combinational from the request inputs.
- `data` is 0 outside RESP.
- Reset (asynchronous, any cycle, including mid-transaction):
  - State returns to IDLE and the counter to 0.
  - All `iresp`/`dresp` fields are 0; `busy` = 0, `err` = 0, `last_grant` = ibus.
  - An in-flight store is discarded.
  - Array contents are not cleared.
- Release of reset takes effect on the first rising edge with `reset` = 1. A request held valid across reset is accepted on that edge.

## Test plan
- Fetch, LATENCY=2: word 0 preloaded with 64'h1111_2222_3333_4444; ireq addr 8000_0004 valid at T → `iresp.data_ok`=1 and `data`=32'h1111_2222 at T+2 only; `dresp` stays 0.
- Store then load: dreq addr 8000_0010, strobe 8'h0F, data 64'hAABB_CCDD_0011_2233 over a word holding all-ones; store `data_ok` at T+2; a following load of the same address returns 64'hFFFF_FFFF_0011_2233.
- Arbitration: ireq and dreq both valid from reset release and held → dbus responds first; ibus responds next, 3 cycles later (LATENCY=2); then the order keeps alternating while both stay valid.
- Out of range: dreq load at addr 0000_1000 → `data_ok` with data 0; `err`=1 from the next cycle and stays 1 through further legal traffic until reset.
- Reset mid-operation: reset pulsed low during WAIT of a store → no `data_ok`, target word unchanged, all outputs 0 while reset is low; the held request is re-accepted after release and completes.
- LATENCY=1 build: back-to-back loads held valid → `data_ok` every 2nd cycle; `busy` toggles 1,0.

Source files
------------

// File: rtl/bus_mem_responder.sv
// Bus types and a single-port memory responder that serves the core's instruction
// and data buses from one 64-bit word array, one transaction at a time.
package bus_mem_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module bus_mem_responder
    import bus_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy,
    output logic       err
);
    localparam int unsigned   AW        = $clog2(MEM_WORDS);
    localparam int unsigned   CW        = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [63:0]   MEM_BYTES = 64'(MEM_WORDS) * 64'd8;
    localparam logic [CW-1:0] CNT_INIT  = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {KIND_FETCH, KIND_LOAD, KIND_STORE} kind_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            gnt_dbus_q, gnt_dbus_d;
    logic            last_dbus_q, last_dbus_d;
    kind_t           kind_q, kind_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            in_range_q, in_range_d;
    logic            addr_hi_q, addr_hi_d;
    logic [7:0]      strobe_q, strobe_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            iok_q, iok_d;
    logic            dok_q, dok_d;
    logic            err_q, err_d;

    logic [63:0]     mem [MEM_WORDS];
    logic [63:0]     rd_word_q;

    logic            accept;
    logic            sel_dbus;
    logic            req_in_range;
    logic            mem_we;
    logic [63:0]     req_addr;
    logic [63:0]     req_off;
    logic            unused_size;

    assign unused_size = ^dreq.size;

    // On a tie the bus that did not win last time is served.
    always_comb begin
        sel_dbus     = dreq.valid && (!ireq.valid || !last_dbus_q);
        req_addr     = sel_dbus ? dreq.addr : ireq.addr;
        req_off      = req_addr - BASE_ADDR;
        req_in_range = (req_addr >= BASE_ADDR) && (req_off < MEM_BYTES);
        accept       = (state_q == ST_IDLE) && (ireq.valid || dreq.valid);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_dbus_d  = gnt_dbus_q;
        last_dbus_d = last_dbus_q;
        kind_d      = kind_q;
        idx_d       = idx_q;
        in_range_d  = in_range_q;
        addr_hi_d   = addr_hi_q;
        strobe_d    = strobe_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    cnt_d       = CNT_INIT;
                    gnt_dbus_d  = sel_dbus;
                    last_dbus_d = sel_dbus;
                    kind_d      = !sel_dbus ? KIND_FETCH :
                                  (|dreq.strobe ? KIND_STORE : KIND_LOAD);
                    idx_d       = req_off[3 +: AW];
                    in_range_d  = req_in_range;
                    addr_hi_d   = req_addr[2];
                    strobe_d    = dreq.strobe;
                    wdata_d     = dreq.data;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (!in_range_q) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Response strobes are registered so they never follow the request inputs.
        iok_d = (state_d == ST_RESP) && !gnt_dbus_d;
        dok_d = (state_d == ST_RESP) && gnt_dbus_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gnt_dbus_q  <= 1'b0;
            last_dbus_q <= 1'b0;
            kind_q      <= KIND_FETCH;
            idx_q       <= '0;
            in_range_q  <= 1'b0;
            addr_hi_q   <= 1'b0;
            strobe_q    <= '0;
            wdata_q     <= '0;
            iok_q       <= 1'b0;
            dok_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_dbus_q  <= gnt_dbus_d;
            last_dbus_q <= last_dbus_d;
            kind_q      <= kind_d;
            idx_q       <= idx_d;
            in_range_q  <= in_range_d;
            addr_hi_q   <= addr_hi_d;
            strobe_q    <= strobe_d;
            wdata_q     <= wdata_d;
            iok_q       <= iok_d;
            dok_q       <= dok_d;
            err_q       <= err_d;
        end
    end

    // Only one transaction is ever in flight and its write lands at the end of RESP,
    // so reading at acceptance yields the same word the RESP cycle would see.
    assign mem_we = (state_q == ST_RESP) && (kind_q == KIND_STORE) && in_range_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_q <= mem[req_off[3 +: AW]];
        end
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (strobe_q[b]) begin
                    mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        iresp         = '0;
        dresp         = '0;
        iresp.addr_ok = iok_q;
        iresp.data_ok = iok_q;
        dresp.addr_ok = dok_q;
        dresp.data_ok = dok_q;
        if (iok_q && in_range_q) begin
            iresp.data = addr_hi_q ? rd_word_q[63:32] : rd_word_q[31:0];
        end
        if (dok_q && in_range_q) begin
            dresp.data = rd_word_q;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: expected responses are queued as requests
// are driven and matched against each data_ok pulse, with a LATENCY=1 side instance.
module tb_bus_mem_responder;
    import bus_mem_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] LIMIT = 64'h8000_8000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    ibus_req_t  ireq, ireq1;
    ibus_resp_t iresp, iresp1;
    dbus_req_t  dreq, dreq1;
    dbus_resp_t dresp, dresp1;
    logic       busy, err, busy1, err1;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        bit          is_d;
        bit          chk;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mdl [int];

    bus_mem_responder #(.MEM_WORDS(4096), .LATENCY(2), .BASE_ADDR(64'h8000_0000)) u_dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
        .dreq(dreq), .dresp(dresp), .busy(busy), .err(err)
    );

    bus_mem_responder #(.MEM_WORDS(4096), .LATENCY(1), .BASE_ADDR(64'h8000_0000)) u_dut1 (
        .clk(clk), .reset(reset), .ireq(ireq1), .iresp(iresp1),
        .dreq(dreq1), .dresp(dresp1), .busy(busy1), .err(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read value comes from the model before the store is folded in.
    task automatic push_exp(input bit is_d, input logic [63:0] addr, input logic [7:0] strobe,
                            input logic [63:0] wdata, input int due);
        exp_t        e;
        int          i;
        logic [63:0] w;
        e.is_d = is_d;
        e.due  = due;
        e.chk  = 1'b1;
        e.data = '0;
        if (addr >= BASE && addr < LIMIT) begin
            i = int'((addr - BASE) >> 3);
            if (mdl.exists(i)) begin
                w = mdl[i];
                e.data = is_d ? w : (addr[2] ? {32'h0, w[63:32]} : {32'h0, w[31:0]});
            end else begin
                e.chk = 1'b0;
            end
            if (is_d && strobe != 8'h00 && (mdl.exists(i) || strobe == 8'hFF)) begin
                w = mdl.exists(i) ? mdl[i] : '0;
                for (int b = 0; b < 8; b++) begin
                    if (strobe[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
                end
                mdl[i] = w;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input string tag);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = iresp.data_ok || dresp.data_ok;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        if (!seen) return;
        total++;
        assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL %s_queue observed=unexpected_response expected=none", tag);
        end
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({tag, "_bus"}, 64'(dresp.data_ok), 64'(e.is_d));
        check({tag, "_cycle"}, 64'(cyc), 64'(e.due));
        check({tag, "_addr_ok"}, 64'({iresp.addr_ok, dresp.addr_ok}),
              64'({iresp.data_ok, dresp.data_ok}));
        if (e.chk) check({tag, "_data"}, e.is_d ? dresp.data : {32'h0, iresp.data}, e.data);
    endtask

    task automatic issue_i(input logic [63:0] addr, input string tag);
        tick();
        ireq.valid = 1'b1;
        ireq.addr  = addr;
        push_exp(1'b0, addr, 8'h00, 64'h0, cyc + 2);
        wait_resp(tag);
        ireq.valid = 1'b0;
    endtask

    task automatic issue_d(input logic [63:0] addr, input logic [7:0] strobe,
                           input logic [63:0] data, input string tag);
        tick();
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = 3'd3;
        dreq.strobe = strobe;
        dreq.data   = data;
        push_exp(1'b1, addr, strobe, data, cyc + 2);
        wait_resp(tag);
        dreq.valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (!iresp.data_ok) check("i_idle_data", {32'h0, iresp.data}, 64'h0);
            if (!dresp.data_ok) check("d_idle_data", dresp.data, 64'h0);
            check("single_grant", 64'(iresp.data_ok & dresp.data_ok), 64'h0);
        end
    end

    initial begin
        int n;
        ireq  = '0;
        dreq  = '0;
        ireq1 = '0;
        dreq1 = '0;
        reset = 1'b0;
        ireq.valid = 1'b1;
        ireq.addr  = BASE;
        repeat (3) tick();
        check("rst_iresp", 64'(iresp), 64'h0);
        check("rst_dresp_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'h0);
        check("rst_dresp_data", dresp.data, 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        ireq.valid = 1'b0;
        reset = 1'b1;

        issue_d(BASE, 8'hFF, 64'h1111_2222_3333_4444, "preload_w0");
        issue_i(BASE + 64'h4, "fetch_hi");
        issue_i(BASE, "fetch_lo");
        issue_d(BASE + 64'h10, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, "fill_ones");
        issue_d(BASE + 64'h10, 8'h0F, 64'hAABB_CCDD_0011_2233, "store_low");
        issue_d(BASE + 64'h10, 8'h00, 64'h0, "load_merged");
        issue_d(BASE + 64'h7FF8, 8'hFF, 64'h5555_6666_7777_8888, "top_store");
        issue_d(BASE + 64'h7FF8, 8'h00, 64'h0, "top_load");
        check("err_before_oor", 64'(err), 64'h0);

        issue_d(LIMIT, 8'hFF, 64'h9999_9999_9999_9999, "oor_store");
        check("err_in_resp", 64'(err), 64'h0);
        tick();
        check("err_after_oor", 64'(err), 64'h1);
        issue_i(BASE, "w0_after_oor");
        issue_d(64'h0000_1000, 8'h00, 64'h0, "oor_load");
        issue_i(64'h7FFF_FFFC, "oor_fetch");
        check("err_sticky", 64'(err), 64'h1);

        // Tie from reset release: dbus first, then strict alternation.
        tick();
        reset = 1'b0;
        tick();
        check("err_cleared", 64'(err), 64'h0);
        ireq.valid  = 1'b1;
        ireq.addr   = BASE + 64'h4;
        dreq.valid  = 1'b1;
        dreq.addr   = BASE + 64'h10;
        dreq.strobe = 8'h00;
        tick();
        reset = 1'b1;
        n = cyc;
        push_exp(1'b1, BASE + 64'h10, 8'h00, 64'h0, n + 2);
        push_exp(1'b0, BASE + 64'h4, 8'h00, 64'h0, n + 5);
        push_exp(1'b1, BASE + 64'h10, 8'h00, 64'h0, n + 8);
        push_exp(1'b0, BASE + 64'h4, 8'h00, 64'h0, n + 11);
        wait_resp("arb_d1");
        wait_resp("arb_i1");
        wait_resp("arb_d2");
        wait_resp("arb_i2");
        ireq.valid = 1'b0;
        dreq.valid = 1'b0;

        // Reset during WAIT of a store, request held across it.
        issue_d(BASE + 64'h20, 8'hFF, 64'h0123_4567_89AB_CDEF, "mid_pre");
        tick();
        dreq.valid  = 1'b1;
        dreq.addr   = BASE + 64'h20;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        check("mid_busy_wait", 64'(busy), 64'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("mid_rst_dresp_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'h0);
        check("mid_rst_dresp_data", dresp.data, 64'h0);
        check("mid_rst_iresp", 64'(iresp), 64'h0);
        tick();
        check("mid_rst_no_ok", 64'(dresp.data_ok), 64'h0);
        reset = 1'b1;
        push_exp(1'b1, BASE + 64'h20, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, cyc + 2);
        wait_resp("mid_replay");
        dreq.valid = 1'b0;
        issue_d(BASE + 64'h20, 8'h00, 64'h0, "mid_readback");

        // LATENCY=1 instance: back-to-back held loads.
        tick();
        dreq1.valid  = 1'b1;
        dreq1.addr   = BASE + 64'h40;
        dreq1.size   = 3'd3;
        dreq1.strobe = 8'hFF;
        dreq1.data   = 64'h7777_8888_9999_AAAA;
        tick();
        check("l1_store_ok", 64'(dresp1.data_ok), 64'h1);
        dreq1.valid = 1'b0;
        tick();
        check("l1_idle_busy", 64'(busy1), 64'h0);
        dreq1.valid  = 1'b1;
        dreq1.strobe = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("l1_busy", 64'(busy1), 64'(k % 2));
            check("l1_ok", 64'(dresp1.data_ok), 64'(k % 2));
            if (k % 2 == 1) check("l1_data", dresp1.data, 64'h7777_8888_9999_AAAA);
        end
        dreq1.valid = 1'b0;
        check("l1_iresp", 64'(iresp1), 64'h0);
        check("l1_err", 64'(err1), 64'h0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
